pwm_capture: RTL and testbench

- Measures an incoming PWM waveform, the receive-side counterpart of the board's LED PWM generator.
- Synchronises an asynchronous PWM input to CLK_IN and counts clock cycles between successive rising edges (period) and cycles spent high (high time).
- Publishes each completed measurement with a one-cycle VALID strobe.
- Used for loopback testing of the LED PWM outputs and for reading external PWM sensors.

---
 rtl/pwm_capture_if.sv | 26 ++
 rtl/pwm_capture.sv | 143 ++++++++++++++
 tb/tb_pwm_capture.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// Purpose : measurement bundle between a PWM source/consumer and pwm_capture.
// Latency : none, wires only.
// Backpressure: none; results are strobed and held, the consumer samples them on o_valid.
// Signals : i_pwm (async PWM in), o_period/o_high (last result), o_valid (1-cycle strobe),
//           o_timeout (no rising edge for 2^WIDTH-1 cycles), o_level (synchronised level).
interface pwm_capture_if #(
   parameter int WIDTH = 12
);
   logic             i_pwm;
   logic [WIDTH-1:0] o_period;
   logic [WIDTH-1:0] o_high;
   logic             o_valid;
   logic             o_timeout;
   logic             o_level;

   // master drives the waveform and reads results; slave is the capture block
   modport master (
      output i_pwm,
      input  o_period, o_high, o_valid, o_timeout, o_level
   );

   modport slave (
      input  i_pwm,
      output o_period, o_high, o_valid, o_timeout, o_level
   );
endinterface

// File: rtl/pwm_capture.sv
// Purpose : measures period and high time (in i_clk cycles) of an asynchronous PWM input.
// Latency : result strobes SYNC_STAGES cycles after the edge that samples the rising PWM edge.
// Backpressure: none; each result overwrites the last and is held until the next o_valid.
// Ports   : i_clk, i_rst (async, active-high), io_cap (slave modport: i_pwm in;
//           o_period, o_high, o_valid, o_timeout, o_level out).
module pwm_capture #(
   parameter int WIDTH       = 12,
   parameter int SYNC_STAGES = 2    // legal values: 2 or 3
) (
   input  logic          i_clk,
   input  logic          i_rst,
   pwm_capture_if.slave  io_cap
);

   localparam logic [WIDTH-1:0] MAXCNT = '1;
   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEASURE,
      ST_STALLED
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_d;
   logic                   w_s;
   logic                   w_rise;

   logic [WIDTH-1:0]       r_pcnt;
   logic [WIDTH-1:0]       r_hcnt;
   logic [WIDTH-1:0]       r_period;
   logic [WIDTH-1:0]       r_high;
   logic                   r_valid;
   logic                   r_timeout;

   logic                   w_load;     // rising edge: restart both counters at 1
   logic                   w_count;    // mid-period cycle: advance counters
   logic                   w_publish;  // completed period: copy counters to outputs
   logic                   w_stall;    // counter hit saturation without an edge

   assign w_s    = r_sync[SYNC_STAGES-1];
   assign w_rise = w_s & ~r_s_d;

   // ---------------- state register ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- next state / control ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_count     = 1'b0;
      w_publish   = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // first edge only opens a period, nothing to report yet
            if (w_rise) begin
               w_load      = 1'b1;
               w_state_nxt = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            // an edge on the saturation cycle still completes a valid MAXCNT period
            if (w_rise) begin
               w_load    = 1'b1;
               w_publish = 1'b1;
            end else if (r_pcnt == MAXCNT) begin
               w_stall     = 1'b1;
               w_state_nxt = ST_STALLED;
            end else begin
               w_count = 1'b1;
            end
         end
         ST_STALLED: begin
            // the stalled period is too long to report; just restart
            if (w_rise) begin
               w_load      = 1'b1;
               w_state_nxt = ST_MEASURE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------- synchroniser, counters, outputs ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync    <= '0;
         r_s_d     <= 1'b0;
         r_pcnt    <= '0;
         r_hcnt    <= '0;
         r_period  <= '0;
         r_high    <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], io_cap.i_pwm};
         r_s_d   <= w_s;
         r_valid <= w_publish;

         if (w_publish) begin
            r_period <= r_pcnt;
            r_high   <= r_hcnt;
         end

         // the rise cycle itself is high, hence both counters start at 1;
         // hcnt only advances alongside pcnt so it can never overtake it
         if (w_load) begin
            r_pcnt <= ONE;
            r_hcnt <= ONE;
         end else if (w_count) begin
            r_pcnt <= r_pcnt + ONE;
            if (w_s) begin
               r_hcnt <= r_hcnt + ONE;
            end
         end

         if (w_stall) begin
            r_timeout <= 1'b1;
         end else if (w_load) begin
            r_timeout <= 1'b0;
         end
      end
   end

   assign io_cap.o_period  = r_period;
   assign io_cap.o_high    = r_high;
   assign io_cap.o_valid   = r_valid;
   assign io_cap.o_timeout = r_timeout;
   assign io_cap.o_level   = w_s;

endmodule

// File: tb/tb_pwm_capture.sv
// Purpose : self-checking bench for pwm_capture (table vectors, hand sequences, random waveforms).
// Latency : n/a.
// Backpressure: n/a.
module tb_pwm_capture;

   localparam int WIDTH  = 12;
   localparam int MAXCNT = (1 << WIDTH) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pwm_capture_if #(.WIDTH(WIDTH)) cap_if ();

   pwm_capture #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_cap (cap_if)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model: works on the per-edge sample history of the input.
   // A measurement is the distance between two rising samples, reported two
   // edges after the later one; gaps longer than MAXCNT are not reported and
   // raise timeout from the point the gap reaches MAXCNT.
   int   edge_n;
   logic h0, h1, h2, h3;
   bit   have_ref;
   int   tr;
   int   ones;
   int   m_period, m_high;
   bit   m_valid, m_timeout, m_level;

   // observations of the DUT used by hand sequences
   int dut_valids;
   int last_valid_edge;
   int first_to_edge;

   typedef struct {
      int p;
      int h;
      int n;
      int exp_valids;
      int exp_period;
      int exp_high;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d got=%0d expected=%0d", name, edge_n, act, exp);
      end
   endtask

   function automatic void model_clear();
      h0 = 0; h1 = 0; h2 = 0; h3 = 0;
      have_ref  = 0;
      tr        = 0;
      ones      = 0;
      m_period  = 0;
      m_high    = 0;
      m_valid   = 0;
      m_timeout = 0;
      m_level   = 0;
   endfunction

   function automatic void model_step(input logic v);
      int r;
      h3 = h2; h2 = h1; h1 = h0; h0 = v;
      r       = edge_n - 2;
      m_valid = 0;
      m_level = h1;
      if (h2 && !h3) begin
         if (have_ref && (r - tr) <= MAXCNT) begin
            m_valid  = 1;
            m_period = r - tr;
            m_high   = ones;
         end
         have_ref  = 1;
         tr        = r;
         ones      = 0;
         m_timeout = 0;
      end else if (have_ref && (r - tr) >= MAXCNT) begin
         m_timeout = 1;
      end
      if (have_ref) ones += int'(h2);
   endfunction

   task automatic tick(input logic v);
      cap_if.i_pwm = v;
      @(posedge clk);
      #1;
      edge_n++;
      model_step(v);
      check("valid",   cap_if.o_valid,   m_valid);
      check("timeout", cap_if.o_timeout, m_timeout);
      check("level",   cap_if.o_level,   m_level);
      check("period",  cap_if.o_period,  m_period);
      check("high",    cap_if.o_high,    m_high);
      if (cap_if.o_valid === 1'b1) begin
         dut_valids++;
         last_valid_edge = edge_n;
      end
      if (cap_if.o_timeout === 1'b1 && first_to_edge < 0) first_to_edge = edge_n;
   endtask

   task automatic run_pwm(input int p, input int h, input int n);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < p; i++) tick(i < h);
      end
   endtask

   task automatic hold(input logic v, input int n);
      for (int i = 0; i < n; i++) tick(v);
   endtask

   // asynchronous reset asserted mid-cycle; outputs must clear before any edge
   task automatic do_reset();
      cap_if.i_pwm = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_period",  cap_if.o_period,  0);
      check("rst_high",    cap_if.o_high,    0);
      check("rst_valid",   cap_if.o_valid,   0);
      check("rst_timeout", cap_if.o_timeout, 0);
      check("rst_level",   cap_if.o_level,   0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      dut_valids    = 0;
      first_to_edge = -1;
   endtask

   initial begin
      int r_edge;
      int base;

      cap_if.i_pwm  = 1'b0;
      edge_n        = 0;
      dut_valids    = 0;
      last_valid_edge = -1;
      first_to_edge = -1;
      model_clear();

      vecs[0] = '{100, 25, 3, 3, 100, 25};
      vecs[1] = '{2, 1, 8, 8, 2, 1};
      vecs[2] = '{3, 1, 5, 5, 3, 1};
      vecs[3] = '{10, 9, 4, 4, 10, 9};
      vecs[4] = '{MAXCNT, 1, 1, 1, MAXCNT, 1};
      vecs[5] = '{MAXCNT + 1, 5, 1, 0, 0, 0};

      // ---- table: n periods then one closing rise => n results ----
      for (int v = 0; v < 6; v++) begin
         do_reset();
         run_pwm(vecs[v].p, vecs[v].h, vecs[v].n);
         hold(1'b1, 1);
         hold(1'b0, 3);
         check("vec_valids", dut_valids,      vecs[v].exp_valids);
         check("vec_period", cap_if.o_period, vecs[v].exp_period);
         check("vec_high",   cap_if.o_high,   vecs[v].exp_high);
         check("vec_timeout", cap_if.o_timeout, 0);
      end

      // ---- lock, duty change, stuck high, resume, stuck low ----
      do_reset();
      run_pwm(100, 25, 10);
      check("lock_valids", dut_valids, 9);
      check("lock_period", cap_if.o_period, 100);
      check("lock_high",   cap_if.o_high,   25);
      run_pwm(100, 75, 5);
      check("duty_period", cap_if.o_period, 100);
      check("duty_high",   cap_if.o_high,   75);
      tick(1'b1);
      r_edge        = edge_n;
      base          = dut_valids;
      first_to_edge = -1;
      hold(1'b1, 4999);
      check("stuck1_to_edge", first_to_edge, r_edge + 2 + MAXCNT);
      check("stuck1_valids",  dut_valids - base, 1);
      check("stuck1_timeout", cap_if.o_timeout, 1);
      check("stuck1_level",   cap_if.o_level, 1);
      check("stuck1_period",  cap_if.o_period, 100);
      check("stuck1_high",    cap_if.o_high, 75);
      base = dut_valids;
      run_pwm(50, 10, 3);
      check("resume_valids",  dut_valids - base, 1);
      check("resume_period",  cap_if.o_period, 50);
      check("resume_high",    cap_if.o_high, 10);
      check("resume_timeout", cap_if.o_timeout, 0);
      base = dut_valids;
      hold(1'b0, 5000);
      check("stuck0_valids",  dut_valids - base, 0);
      check("stuck0_timeout", cap_if.o_timeout, 1);
      check("stuck0_level",   cap_if.o_level, 0);
      check("stuck0_period",  cap_if.o_period, 50);
      check("stuck0_high",    cap_if.o_high, 10);

      // ---- reset in the low phase of a locked waveform ----
      do_reset();
      run_pwm(100, 25, 3);
      hold(1'b1, 25);
      hold(1'b0, 30);
      do_reset();
      hold(1'b0, 45);
      run_pwm(100, 25, 2);
      check("rst_mid_valids", dut_valids, 1);
      check("rst_mid_period", cap_if.o_period, 100);
      check("rst_mid_high",   cap_if.o_high, 25);

      // ---- edge latency: rise sampled at edge k, result after edge k+2 ----
      do_reset();
      run_pwm(20, 10, 3);
      hold(1'b0, 5);
      tick(1'b1);
      check("lat_k",  cap_if.o_valid, 0);
      tick(1'b1);
      check("lat_k1", cap_if.o_valid, 0);
      tick(1'b1);
      check("lat_k2", cap_if.o_valid, 1);
      check("lat_period", cap_if.o_period, 25);
      check("lat_high",   cap_if.o_high, 10);
      hold(1'b1, 7);
      hold(1'b0, 10);

      // ---- randomized waveforms against the reference model ----
      do_reset();
      for (int s = 0; s < 30; s++) begin
         if ($urandom_range(0, 9) == 0) begin
            hold(1'($urandom_range(0, 1)), int'($urandom_range(3000, 4300)));
         end else begin
            int p;
            int h;
            p = int'($urandom_range(2, 300));
            h = int'($urandom_range(1, p - 1));
            run_pwm(p, h, int'($urandom_range(1, 4)));
         end
      end
      hold(1'b0, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
